// File: rtl/clk_gate_ctrl.sv
// Registered CLK_EN/CLK_RDY generator for a latch-based clock gate.
// Optional activity counter enabled by macro CG_ACT_CNT_EN.
module clk_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        GATE_REQ,
  input  logic        BUSY,
`ifdef CG_ACT_CNT_EN
  input  logic        CNT_CLR,
  output logic [15:0] ACT_CNT,
`endif
  output logic        CLK_EN,
  output logic        CLK_RDY
);

  typedef enum logic [1:0] {
    OFF,
    WAKE,
    ON,
    HOLD
  } state_e;

  localparam logic [CNT_WIDTH-1:0] WakeLd = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IdleLd = CNT_WIDTH'(IDLE_CYCLES - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 en_q;
  logic                 rdy_q;
  logic                 act;
  logic                 cnt_zero;

  assign act      = GATE_REQ | BUSY;
  assign cnt_zero = (cnt_q == '0);

  // Outputs are written alongside the state so they are pure flop outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          if (GATE_REQ) begin
            state_q <= WAKE;
            cnt_q   <= WakeLd;
            en_q    <= 1'b1;
            rdy_q   <= 1'b0;
          end
        end
        WAKE: begin
          if (cnt_zero) begin
            rdy_q <= 1'b1;
            if (act) begin
              state_q <= ON;
            end else begin
              state_q <= HOLD;
              cnt_q   <= IdleLd;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ON: begin
          if (!act) begin
            state_q <= HOLD;
            cnt_q   <= IdleLd;
          end
        end
        HOLD: begin
          if (act) begin
            state_q <= ON;
          end else if (cnt_zero) begin
            state_q <= OFF;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign CLK_EN  = en_q;
  assign CLK_RDY = rdy_q;

`ifdef CG_ACT_CNT_EN
  logic [15:0] act_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      act_cnt_q <= '0;
    end else if (CNT_CLR) begin
      act_cnt_q <= '0;
    end else if (en_q && (act_cnt_q != 16'hFFFF)) begin
      act_cnt_q <= act_cnt_q + 16'd1;
    end
  end

  assign ACT_CNT = act_cnt_q;
`endif

endmodule
